// File: rtl/branch_pkg.sv
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types, opcode constants and FSM state encodings for the
//                branch execution stage and its compare helper.
//                Contents: addr_t / word_t / sinst_t / regtag_t, c_unlocked,
//                c_op_beq .. c_op_jalr, state_t.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int OP_W   = 6;
    localparam int TAG_W  = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [OP_W-1:0]   sinst_t;
    typedef logic [TAG_W-1:0]  regtag_t;

    // A tag of all ones means the operand value is already present.
    localparam regtag_t c_unlocked = {TAG_W{1'b1}};

    localparam sinst_t c_op_beq  = 6'd0;
    localparam sinst_t c_op_bne  = 6'd1;
    localparam sinst_t c_op_blt  = 6'd2;
    localparam sinst_t c_op_bge  = 6'd3;
    localparam sinst_t c_op_bltu = 6'd4;
    localparam sinst_t c_op_bgeu = 6'd5;
    localparam sinst_t c_op_jal  = 6'd6;
    localparam sinst_t c_op_jalr = 6'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_cmp.sv
// ============================================================================
//  Module      : branch_cmp
//  Description : Purely combinational branch condition evaluator. Also used by
//                the ALU for SLT/SLTU, so it carries no state.
//                Ports: op (in)  branch opcode
//                       a  (in)  operand x
//                       b  (in)  operand y
//                       taken (out) condition result; 0 for unknown opcodes
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cmp
    import branch_pkg::*;
(
    input  sinst_t op,
    input  word_t  a,
    input  word_t  b,
    output logic   taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            c_op_beq  : taken = (a == b);
            c_op_bne  : taken = (a != b);
            c_op_blt  : taken = ($signed(a) <  $signed(b));
            c_op_bge  : taken = ($signed(a) >= $signed(b));
            c_op_bltu : taken = (a <  b);
            c_op_bgeu : taken = (a >= b);
            c_op_jal  : taken = 1'b1;
            c_op_jalr : taken = 1'b1;
            default   : taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_unit.sv
// ============================================================================
//  Module      : branch_unit
//  Description : Branch execution stage behind the branch reservation station.
//                Captures a ready entry, resolves it, and holds a redirect to
//                fetch for taken branches / jumps until fetch acknowledges.
//                Ports: clk, rst (async, active high), rdy (global enable)
//                       rs_busy/rs_pc/rs_offset/rs_op/rs_tag*/rs_data*  (in)
//                       busy_branch, unit_stall                         (out)
//                       jump_en, jump_addr (out), jump_ack (in)
//                       resolve_en, resolve_taken                       (out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_unit
    import branch_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    input  logic    rs_busy,
    input  addr_t   rs_pc,
    input  word_t   rs_offset,
    input  sinst_t  rs_op,
    input  regtag_t rs_tagx,
    input  regtag_t rs_tagy,
    input  word_t   rs_datax,
    input  word_t   rs_datay,
    output logic    busy_branch,
    output logic    unit_stall,
    output logic    jump_en,
    output addr_t   jump_addr,
    input  logic    jump_ack,
    output logic    resolve_en,
    output logic    resolve_taken
);

    state_t r_state;
    state_t w_state_next;

    addr_t  r_pc;
    sinst_t r_op;
    word_t  r_offset;
    word_t  r_datax;
    word_t  r_datay;

    logic   r_jump_en;
    addr_t  r_jump_addr;
    logic   r_resolve_en;
    logic   r_resolve_taken;

    logic   w_ready;
    logic   w_capture;
    logic   w_taken;
    word_t  w_sum;
    addr_t  w_target;
    logic   w_jump_en_next;
    addr_t  w_jump_addr_next;
    logic   w_resolve_en_next;
    logic   w_resolve_taken_next;

    assign w_ready     = rs_busy && (rs_tagx == c_unlocked) && (rs_tagy == c_unlocked);
    // The entry is consumed only in the cycle the unit actually captures it.
    assign busy_branch = rs_busy && !((r_state == ST_IDLE) && w_ready);
    assign unit_stall  = (r_state != ST_IDLE);

    branch_cmp u_cmp (
        .op    (r_op),
        .a     (r_datax),
        .b     (r_datay),
        .taken (w_taken)
    );

    // JALR is register-relative with bit 0 forced low; everything else is
    // pc-relative. Misaligned results are passed on untouched for fetch to trap.
    assign w_sum    = (r_op == c_op_jalr) ? (r_datax + r_offset) : (r_pc + r_offset);
    assign w_target = (r_op == c_op_jalr) ? {w_sum[ADDR_W-1:1], 1'b0} : w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_capture            = 1'b0;
        w_jump_en_next       = r_jump_en;
        w_jump_addr_next     = r_jump_addr;
        w_resolve_en_next    = 1'b0;  // pulse: never held, even while rdy is low
        w_resolve_taken_next = r_resolve_taken;
        if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ready) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_taken) begin
                        w_jump_en_next   = 1'b1;
                        w_jump_addr_next = w_target;
                        w_state_next     = ST_REDIRECT;
                    end else begin
                        w_resolve_en_next    = 1'b1;
                        w_resolve_taken_next = 1'b0;
                        w_state_next         = ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (jump_ack) begin
                        w_jump_en_next       = 1'b0;
                        w_resolve_en_next    = 1'b1;
                        w_resolve_taken_next = 1'b1;
                        w_state_next         = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= '0;
            r_op            <= '0;
            r_offset        <= '0;
            r_datax         <= '0;
            r_datay         <= '0;
            r_jump_en       <= 1'b0;
            r_jump_addr     <= '0;
            r_resolve_en    <= 1'b0;
            r_resolve_taken <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pc     <= rs_pc;
                r_op     <= rs_op;
                r_offset <= rs_offset;
                r_datax  <= rs_datax;
                r_datay  <= rs_datay;
            end
            r_jump_en       <= w_jump_en_next;
            r_jump_addr     <= w_jump_addr_next;
            r_resolve_en    <= w_resolve_en_next;
            r_resolve_taken <= w_resolve_taken_next;
        end
    end

    assign jump_en       = r_jump_en;
    assign jump_addr     = r_jump_addr;
    assign resolve_en    = r_resolve_en;
    assign resolve_taken = r_resolve_taken;

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
// ============================================================================
//  Module      : tb_branch_unit
//  Description : Scoreboard bench for branch_unit. The driver pushes expected
//                redirects and resolutions into queues; a monitor pops them as
//                the unit presents jump_en rising edges and resolve_en pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_unit;
    import branch_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    rdy;
    logic    rs_busy;
    addr_t   rs_pc;
    word_t   rs_offset;
    sinst_t  rs_op;
    regtag_t rs_tagx;
    regtag_t rs_tagy;
    word_t   rs_datax;
    word_t   rs_datay;
    logic    busy_branch;
    logic    unit_stall;
    logic    jump_en;
    addr_t   jump_addr;
    logic    jump_ack;
    logic    resolve_en;
    logic    resolve_taken;

    int checks = 0;
    int errors = 0;

    logic  exp_resolve_q[$];
    addr_t exp_redirect_q[$];
    logic  prev_jump_en = 1'b0;

    always #5 clk = ~clk;

    branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .rs_busy       (rs_busy),
        .rs_pc         (rs_pc),
        .rs_offset     (rs_offset),
        .rs_op         (rs_op),
        .rs_tagx       (rs_tagx),
        .rs_tagy       (rs_tagy),
        .rs_datax      (rs_datax),
        .rs_datay      (rs_datay),
        .busy_branch   (busy_branch),
        .unit_stall    (unit_stall),
        .jump_en       (jump_en),
        .jump_addr     (jump_addr),
        .jump_ack      (jump_ack),
        .resolve_en    (resolve_en),
        .resolve_taken (resolve_taken)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every resolve pulse and every new redirect must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_jump_en = 1'b0;
        end else begin
            if (resolve_en) begin
                if (exp_resolve_q.size() == 0) begin
                    check("unexpected_resolve", 32'(resolve_en), 32'd0);
                end else begin
                    check("resolve_taken", 32'(resolve_taken), 32'(exp_resolve_q.pop_front()));
                end
            end
            if (jump_en && !prev_jump_en) begin
                if (exp_redirect_q.size() == 0) begin
                    check("unexpected_redirect", 32'(jump_en), 32'd0);
                end else begin
                    check("jump_addr", jump_addr, exp_redirect_q.pop_front());
                end
            end
            prev_jump_en = jump_en;
        end
    end

    task automatic drive_entry(input sinst_t op, input addr_t pc, input word_t off,
                               input word_t x, input word_t y);
        rs_busy   = 1'b1;
        rs_op     = op;
        rs_pc     = pc;
        rs_offset = off;
        rs_datax  = x;
        rs_datay  = y;
        rs_tagy   = c_unlocked;
    endtask

    // One complete branch: optional locked-tag wait, capture, resolve, and for
    // taken branches a redirect held ack_delay extra cycles and frozen for
    // freeze cycles with rdy low before fetch accepts it.
    task automatic send(input sinst_t op, input addr_t pc, input word_t off,
                        input word_t x, input word_t y, input logic exp_taken,
                        input addr_t exp_addr, input int lock_cycles,
                        input int ack_delay, input int freeze);
        @(negedge clk);
        drive_entry(op, pc, off, x, y);
        rs_tagx = (lock_cycles > 0) ? 4'd3 : c_unlocked;
        for (int i = 0; i < lock_cycles; i++) begin
            @(negedge clk);
            check("locked_busy_branch", 32'(busy_branch), 32'd1);
            check("locked_unit_stall", 32'(unit_stall), 32'd0);
        end
        rs_tagx = c_unlocked;
        #1;
        check("capture_busy_branch", 32'(busy_branch), 32'd0);
        exp_resolve_q.push_back(exp_taken);
        if (exp_taken) exp_redirect_q.push_back(exp_addr);
        @(posedge clk); #1;
        rs_busy = 1'b0;
        check("exec_unit_stall", 32'(unit_stall), 32'd1);
        check("exec_no_jump", 32'(jump_en), 32'd0);
        @(posedge clk); #1;
        check("lat2_jump_en", 32'(jump_en), 32'(exp_taken));
        check("lat2_resolve_en", 32'(resolve_en), 32'(!exp_taken));
        if (exp_taken) begin
            for (int i = 0; i < ack_delay; i++) begin
                @(negedge clk);
                check("hold_jump_en", 32'(jump_en), 32'd1);
                check("hold_jump_addr", jump_addr, exp_addr);
            end
            @(negedge clk);
            jump_ack = 1'b1;
            rdy      = (freeze == 0);
            for (int i = 0; i < freeze; i++) begin
                @(posedge clk); #1;
                check("freeze_jump_en", 32'(jump_en), 32'd1);
                check("freeze_jump_addr", jump_addr, exp_addr);
                check("freeze_resolve_en", 32'(resolve_en), 32'd0);
            end
            rdy = 1'b1;
            @(posedge clk); #1;
            jump_ack = 1'b0;
            check("ack_jump_en", 32'(jump_en), 32'd0);
            check("ack_resolve_en", 32'(resolve_en), 32'd1);
            check("ack_unit_stall", 32'(unit_stall), 32'd0);
        end else begin
            check("nt_unit_stall", 32'(unit_stall), 32'd0);
            @(posedge clk); #1;
            check("nt_jump_en", 32'(jump_en), 32'd0);
            check("nt_resolve_drop", 32'(resolve_en), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        rs_busy  = 1'b0;
        rs_pc    = '0;
        rs_offset = '0;
        rs_op    = '0;
        rs_tagx  = c_unlocked;
        rs_tagy  = c_unlocked;
        rs_datax = '0;
        rs_datay = '0;
        jump_ack = 1'b0;
        #1;
        check("rst_jump_en", 32'(jump_en), 32'd0);
        check("rst_jump_addr", jump_addr, 32'd0);
        check("rst_resolve_en", 32'(resolve_en), 32'd0);
        check("rst_resolve_taken", 32'(resolve_taken), 32'd0);
        check("rst_unit_stall", 32'(unit_stall), 32'd0);
        check("rst_busy_branch", 32'(busy_branch), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ack while no redirect is pending must do nothing
        @(negedge clk); jump_ack = 1'b1;
        @(posedge clk); #1 jump_ack = 1'b0;
        check("stray_ack_jump_en", 32'(jump_en), 32'd0);
        check("stray_ack_stall", 32'(unit_stall), 32'd0);

        //   op         pc            off           x             y            tkn  target        lock ack frz
        send(c_op_beq,  32'h100,      32'h20,       32'd5,        32'd5,       1'b1, 32'h120,      0, 0, 0);
        send(c_op_blt,  32'h200,      32'h40,       32'hFFFFFFFF, 32'd1,       1'b1, 32'h240,      0, 0, 0);
        send(c_op_bltu, 32'h200,      32'h40,       32'hFFFFFFFF, 32'd1,       1'b0, 32'h0,        0, 0, 0);
        send(c_op_jalr, 32'h300,      32'd4,        32'h1003,     32'd0,       1'b1, 32'h1006,     0, 5, 0);
        send(c_op_beq,  32'h400,      32'h8,        32'd7,        32'd7,       1'b1, 32'h408,      4, 0, 0);
        send(c_op_bne,  32'hFFFFFFF0, 32'h20,       32'd1,        32'd2,       1'b1, 32'h10,       0, 0, 0);
        send(c_op_bge,  32'h500,      32'hFFFFFFF0, 32'd1,        32'hFFFFFFFF, 1'b1, 32'h4F0,     0, 1, 0);
        send(c_op_bgeu, 32'h500,      32'hFFFFFFF0, 32'd1,        32'hFFFFFFFF, 1'b0, 32'h0,       0, 0, 0);
        send(c_op_jal,  32'h600,      32'd6,        32'd0,        32'd0,       1'b1, 32'h606,      0, 0, 3);
        send(c_op_bne,  32'h900,      32'h10,       32'd9,        32'd9,       1'b0, 32'h0,        0, 0, 0);
        send(6'h3F,     32'hA00,      32'h10,       32'd9,        32'd9,       1'b0, 32'h0,        0, 0, 0);

        // asynchronous reset in the middle of a redirect
        @(negedge clk);
        drive_entry(c_op_beq, 32'h700, 32'h10, 32'd1, 32'd1);
        rs_tagx = c_unlocked;
        @(posedge clk); #1 rs_busy = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_jump_en", 32'(jump_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_jump_en", 32'(jump_en), 32'd0);
        check("async_rst_resolve_en", 32'(resolve_en), 32'd0);
        check("async_rst_stall", 32'(unit_stall), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("post_rst_resolve_en", 32'(resolve_en), 32'd0);

        send(c_op_bne,  32'h800,      32'h4,        32'd0,        32'd1,       1'b1, 32'h804,      0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("resolve_q_empty", 32'(exp_resolve_q.size()), 32'd0);
        check("redirect_q_empty", 32'(exp_redirect_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
